// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//   Compares two WIDTH-bit unsigned operands two bits per clock, starting with
//   the most significant 2-bit slice. The first unequal slice decides the
//   verdict. Later slices are still shifted through but cannot change it, so
//   latency is always N = WIDTH/2 cycles.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request; sampled only when idle
//   a, b   in   WIDTH  operands, captured with an accepted start
//   busy   out  1      comparison in progress
//   done   out  1      one-cycle pulse: gt/eq/lt were just updated
//   gt     out  1      A >  B, held until the next done
//   eq     out  1      A == B, held until the next done
//   lt     out  1      A <  B, held until the next done
// -----------------------------------------------------------------------------
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             slice_gt_q, slice_gt_d;
  logic             slice_lt_q, slice_lt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [1:0] sa, sb;
  logic       verdict_gt, verdict_lt;

  // Current slice and the verdict including it. Once decided, the stored
  // outcome wins and later slices are ignored.
  assign sa         = sha_q[WIDTH-1 -: 2];
  assign sb         = shb_q[WIDTH-1 -: 2];
  assign verdict_gt = slice_gt_q | (!decided_q && (sa > sb));
  assign verdict_lt = slice_lt_q | (!decided_q && (sa < sb));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    sha_d      = sha_q;
    shb_d      = shb_q;
    cnt_d      = cnt_q;
    decided_d  = decided_q;
    slice_gt_d = slice_gt_q;
    slice_lt_d = slice_lt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gt_d       = gt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sha_d      = a;
          shb_d      = b;
          cnt_d      = CW'(N);
          decided_d  = 1'b0;
          slice_gt_d = 1'b0;
          slice_lt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        slice_gt_d = verdict_gt;
        slice_lt_d = verdict_lt;
        decided_d  = decided_q | (sa != sb);
        sha_d      = sha_q << 2;
        shb_d      = shb_q << 2;
        cnt_d      = cnt_q - 1'b1;
        // cnt_q == 1 marks the least significant slice being evaluated now.
        if (cnt_q == CW'(1)) begin
          gt_d    = verdict_gt;
          lt_d    = verdict_lt;
          eq_d    = !(verdict_gt | verdict_lt);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values of
  // the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sha_q      <= '0;
      shb_q      <= '0;
      cnt_q      <= '0;
      decided_q  <= 1'b0;
      slice_gt_q <= 1'b0;
      slice_lt_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sha_q      <= sha_d;
      shb_q      <= shb_d;
      cnt_q      <= cnt_d;
      decided_q  <= decided_d;
      slice_gt_q <= slice_gt_d;
      slice_lt_q <= slice_lt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule
